// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encodings and R/W bit values.
package i2c_pkg;

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StAddr    = 4'd1,
        StAddrAck = 4'd2,
        StRx      = 4'd3,
        StRxAck   = 4'd4,
        StTx      = 4'd5,
        StTxAck   = 4'd6,
        StIgnore  = 4'd7
    } i2c_state_e;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCLK/SDA into the clk domain and derives edge and START/STOP strobes.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_hist_q;
    logic       sda_hist_q;
    logic       scl_s;

    // Two-flop synchronizers followed by one history flop per line.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], sclk};
            sda_sync_q <= {sda_sync_q[0], sda_in};
            scl_hist_q <= scl_sync_q[1];
            sda_hist_q <= sda_sync_q[1];
        end
    end

    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];

    assign scl_rise  = scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s & scl_hist_q;
    // SCLK must be stable high across both samples so a coincident SCLK edge is not a condition.
    assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C slave: 7-bit addressing, byte receive and transmit with ACK handling.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       sda_in,
    output logic       sda_out,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic [3:0] state
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .sda_in   (sda_in),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    i2c_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_q, sda_d;
    // In ACK states: ACK is being driven. In TX: first bit waits for the next falling edge.
    logic       phase_q, phase_d;
    logic       rw_q, rw_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_load_q, tx_load_d;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            sda_q      <= 1'b1;
            phase_q    <= 1'b0;
            rw_q       <= WRITE;
            rx_valid_q <= 1'b0;
            tx_load_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            sda_q      <= sda_d;
            phase_q    <= phase_d;
            rw_q       <= rw_d;
            rx_valid_q <= rx_valid_d;
            tx_load_q  <= tx_load_d;
        end
    end

    // Next-state logic; bus conditions override any bit event in the same cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        sda_d      = sda_q;
        phase_d    = phase_q;
        rw_d       = rw_q;
        rx_valid_d = 1'b0;
        tx_load_d  = 1'b0;
        if (start_det) begin
            state_d = StAddr;
            cnt_d   = 3'd0;
            sda_d   = 1'b1;
            phase_d = 1'b0;
        end else if (stop_det) begin
            state_d = StIdle;
            cnt_d   = 3'd0;
            sda_d   = 1'b1;
            phase_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StIgnore: sda_d = 1'b1;
                StAddr: if (scl_rise) begin
                    shift_d = {shift_q[6:0], sda_s};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        rw_d    = sda_s;
                        state_d = (shift_q[6:0] == SLAVE_ADDR) ? StAddrAck : StIgnore;
                    end
                end
                StAddrAck: if (scl_fall) begin
                    if (!phase_q) begin
                        sda_d   = 1'b0;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        cnt_d   = 3'd0;
                        if (rw_q == READ) begin
                            state_d   = StTx;
                            shift_d   = tx_data;
                            tx_load_d = 1'b1;
                            sda_d     = tx_data[7];
                        end else begin
                            state_d = StRx;
                            sda_d   = 1'b1;
                        end
                    end
                end
                StRx: if (scl_rise) begin
                    shift_d = {shift_q[6:0], sda_s};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        rx_data_d  = {shift_q[6:0], sda_s};
                        rx_valid_d = 1'b1;
                        state_d    = StRxAck;
                    end
                end
                StRxAck: if (scl_fall) begin
                    if (!phase_q) begin
                        sda_d   = 1'b0;
                        phase_d = 1'b1;
                    end else begin
                        sda_d   = 1'b1;
                        phase_d = 1'b0;
                        state_d = StRx;
                    end
                end
                StTx: if (scl_fall) begin
                    if (phase_q) begin
                        sda_d   = shift_q[7];
                        phase_d = 1'b0;
                    end else if (cnt_q == 3'd7) begin
                        sda_d   = 1'b1;
                        cnt_d   = 3'd0;
                        state_d = StTxAck;
                    end else begin
                        shift_d = {shift_q[6:0], 1'b0};
                        sda_d   = shift_q[6];
                        cnt_d   = cnt_q + 3'd1;
                    end
                end
                StTxAck: if (scl_rise) begin
                    if (!sda_s) begin
                        shift_d   = tx_data;
                        tx_load_d = 1'b1;
                        phase_d   = 1'b1;
                        cnt_d     = 3'd0;
                        state_d   = StTx;
                    end else begin
                        state_d = StIgnore;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign sda_out  = sda_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_load  = tx_load_q;
    assign state    = state_q;
    assign busy     = state_q inside {StAddrAck, StRx, StRxAck, StTx, StTxAck};

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h50, 7-bit bus address this slave answers to.
REQ-002 clk  input  1  single system clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 sclk  input  1  I2C clock from master (asynchronous to clk).
REQ-005 sda_in  input  1  resolved SDA line value.
REQ-006 sda_out  output  1  slave SDA drive: 0 = pull low, 1 = release.
REQ-007 tx_data  input  8  byte returned to master on read transfers.
REQ-008 tx_load  output  1  one-cycle pulse when tx_data has been captured.
REQ-009 rx_data  output  8  last byte written by master.
REQ-010 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-011 busy  output  1  high from address match until STOP or repeated START.
REQ-012 state  output  4  current FSM state (debug).

Function
REQ-013 sclk and sda_in SHALL each pass a 2-flop synchronizer plus one history flop; all edges are decided from synchronized values only.
REQ-014 START = synced SDA falling while synced SCLK high; STOP = synced SDA rising while synced SCLK high.
REQ-015 Bits are MSB first; the slave samples SDA on SCLK rising edges and changes sda_out only on SCLK falling edges.
REQ-016 States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE; encodings 0..7 on state.
REQ-017 IDLE: sda_out=1; START -> ADDR, bit counter cleared.
REQ-018 ADDR: shift 8 bits (7 address + R/W, 1 = read); after 8th rising edge, match -> ADDR_ACK, mismatch -> IGNORE.
REQ-019 ADDR_ACK: drive sda_out=0 from the next SCLK falling edge through the following falling edge; busy=1; then R/W=0 -> RX, R/W=1 -> TX.
REQ-020 On entering TX (the ACK-ending falling edge) tx_data SHALL be captured into the shift register, tx_load pulsed once, and bit 7 driven immediately.
REQ-021 RX: shift 8 bits; after 8th rising edge rx_data updates and rx_valid pulses exactly one clk cycle later; -> RX_ACK.
REQ-022 RX_ACK: sda_out=0 for one SCLK low-high-low ACK slot, then -> RX.
REQ-023 TX: after 8th bit falling edge release SDA, -> TX_ACK.
REQ-024 TX_ACK: sample SDA on rising edge; 0 (ACK) -> reload tx_data, pulse tx_load, -> TX; 1 (NACK) -> IGNORE.
REQ-025 IGNORE: sda_out=1, busy=0; waits for START or STOP.
REQ-026 STOP in any state -> IDLE, sda_out=1, busy=0, no rx_valid for a partial byte.
REQ-027 START in any state (repeated start) -> ADDR, counter cleared, partial byte discarded.
REQ-028 START/STOP detection SHALL take priority over a coincident data-bit event in the same cycle.
REQ-029 Bit counter is 3 bits and wraps 7 -> 0 at each byte boundary; no byte-count limit.

Reset
REQ-030 While rst=1 at a clk edge: state=IDLE, sda_out=1, rx_data=8'h00, rx_valid=0, tx_load=0, busy=0, counter=0, synchronizer flops=1.
REQ-031 Reset asserted mid-transfer SHALL abort immediately and release SDA on the next clk edge; the bus is reacquired only at the next START.

Structure
REQ-032 Shared package i2c_pkg holds the 4-bit state constants and the READ=1/WRITE=0 R/W constants, shared with the master.
REQ-033 One sub-module i2c_bus_sync: synchronizers, SCLK rise/fall strobes, START/STOP strobes.

Verification
REQ-034 Write 0xA0 (addr 0x50 W), data 0x3C, STOP -> ACK on both bytes, rx_data=0x3C, one rx_valid pulse, busy falls at STOP.
REQ-035 Read 0xA1, tx_data=0xF6, master NACK -> SDA carries 11110110 MSB first, one tx_load, state IGNORE then IDLE at STOP.
REQ-036 Address 0x51 write -> no ACK (sda_out stays 1 throughout), no rx_valid, busy=0.
REQ-037 Write 0xA0, 0x11, 0x22 then repeated START + 0xA1 read with master ACK then NACK -> rx_valid twice (0x11, 0x22), two tx_load pulses.
REQ-038 rst pulsed after 4 data bits of a write -> sda_out=1, state IDLE, no rx_valid; next full transaction succeeds.
REQ-039 STOP after 5 data bits -> IDLE, rx_data unchanged, no rx_valid.
